stack_controller: RTL and testbench
===================================

Name: stack_controller

Overview:
- Multi-cycle control FSM for the 8-bit stack-machine datapath; sits directly upstream of it.
- Consumes the datapath's 3-bit opcode and zero flag, and produces every datapath control strobe once per state.
- Sequences fetch, decode and execute for the 8-instruction ISA: ALU ops, PUSH, POP, JMP, JZ.

Parameters:
- RESET_WAIT, 1: number of INIT cycles after reset deasserts before the first FETCH (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; forces INIT and all outputs 0.
- inst_op  in  3  opcode, IR[7:5], from the datapath.
- z  in  1  datapath zero flag; 1 when stack top == 8'h00.
- ir_write  out  1  latch memory data into IR.
- B_write  out  1  latch stack top into operand B.
- pc_src  out  1  0 = IR[4:0] (jump target), 1 = pc+1.
- pc_write  out  1  update pc.
- mem_src  out  1  0 = IR[4:0] (data address), 1 = pc (fetch address).
- mem_write  out  1  write stack top to data memory.
- stack_src  out  1  0 = memory data, 1 = ALU result register.
- tos  out  1  stack read of top: combinational, so stack_out is valid in the same cycle.
- push  out  1  push stack_in.
- pop  out  1  discard top.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT (unary), 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- Outputs are a pure function of state, plus inst_op and z in DECODE. Every output not listed for a state is 0.
- At most one of push and pop is high in any cycle.
- INIT: all outputs 0. A 4-bit counter counts to RESET_WAIT, then the FSM moves to FETCH.
- FETCH: mem_src=1, ir_write=1, pc_src=1, pc_write=1. Next state DECODE.
- DECODE, by opcode:
  - ALU ops 000..011: tos=1, B_write=1, pop=1. 011 goes to ALU_EXEC; the others go to ALU_POP2.
  - PUSH (100): next state PUSH_MEM, no strobes.
  - POP (101): next state POP_MEM, no strobes.
  - JMP (110): pc_src=0, pc_write=1, instr_done=1. Next state FETCH.
  - JZ (111): tos=1. If z=1, pc_src=0, pc_write=1. instr_done=1. Next state FETCH. The stack is unchanged.
- ALU_POP2: tos=1, pop=1. The ALU consumes the new top against B. Next state ALU_EXEC.
- ALU_EXEC: no strobes; the datapath latches alu_reg this edge. Next state ALU_PUSH.
- ALU_PUSH: stack_src=1, push=1, instr_done=1. Next state FETCH.
- PUSH_MEM: mem_src=0, stack_src=0, push=1, instr_done=1. Next state FETCH.
- POP_MEM: tos=1, mem_src=0, mem_write=1, pop=1, instr_done=1. Next state FETCH.
- Instruction latency:
  - JMP, JZ: 2 cycles.
  - PUSH, POP: 3 cycles.
  - NOT: 4 cycles.
  - ADD, SUB, AND: 5 cycles.
- PC wrap: pc+1 wraps 5'd31 to 0 in the datapath; the controller takes no special action.
- Reset mid-instruction: at the next edge with reset=1 the state becomes INIT and all outputs 0 from that edge. No partial push, pop or mem_write is issued after the reset edge.
- Reset held: outputs stay 0 and the INIT counter stays 0. Counting starts on the first edge with reset=0.
- Unknown or X inst_op: the default branch returns to FETCH with no strobes.

Optional Feature:
- SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - FETCH is entered only from a new state HOLD. HOLD follows each instr_done and INIT, outputs all 0, and advances when step=1 at an edge.
  - step held high runs one instruction per pass through HOLD, with no extra skipping.
- When undefined: no step port, no HOLD state, and timing exactly as above.

Test Plan:
- Reset with RESET_WAIT=1: reset=1 for 2 cycles, then 0. All outputs are 0 during reset and the next 1 cycle; FETCH strobes (mem_src=ir_write=pc_src=pc_write=1) appear on cycle 2.
- PUSH: inst_op=100 after FETCH. DECODE has all strobes 0; the next cycle has push=1, stack_src=0, mem_src=0, instr_done=1; then FETCH.
- ADD: inst_op=000. Expect the 5-cycle sequence FETCH, DECODE (tos, B_write, pop), ALU_POP2 (tos, pop), ALU_EXEC (none), ALU_PUSH (push, stack_src=1, instr_done).
- JZ: inst_op=111 with z=1 gives pc_src=0, pc_write=1 in DECODE. Repeat with z=0: pc_write=0, pop=0. Both cases return to FETCH.
- Reset mid-instruction: assert reset during ALU_POP2. The next cycle shows push=pop=mem_write=0, and the FSM restarts from INIT.
- With SINGLE_STEP_EN and step=0: the FSM stays in HOLD for 10 cycles with all outputs 0. A one-cycle step pulse runs exactly one JMP, then returns to HOLD.

Source files
------------

// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - opcode/flag inputs and control strobes between controller and datapath
//
// Signals:
//   inst_op[2:0]  opcode IR[7:5] from the datapath
//   z             datapath zero flag (stack top == 0)
//   ir_write, B_write, pc_src, pc_write, mem_src, mem_write,
//   stack_src, tos, push, pop, instr_done   control strobes to the datapath
// Modports:
//   master  controller side (drives strobes, reads opcode/flag)
//   slave   datapath side
interface stack_controller_if;
    logic [2:0] inst_op;
    logic       z;
    logic       ir_write;
    logic       B_write;
    logic       pc_src;
    logic       pc_write;
    logic       mem_src;
    logic       mem_write;
    logic       stack_src;
    logic       tos;
    logic       push;
    logic       pop;
    logic       instr_done;

    modport master (
        input  inst_op, z,
        output ir_write, B_write, pc_src, pc_write, mem_src, mem_write,
               stack_src, tos, push, pop, instr_done
    );

    modport slave (
        output inst_op, z,
        input  ir_write, B_write, pc_src, pc_write, mem_src, mem_write,
               stack_src, tos, push, pop, instr_done
    );
endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - multi-cycle fetch/decode/execute FSM for the 8-bit stack machine
//
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  synchronous active-high; forces INIT and all strobes low
//   bus    stack_controller_if.master: inst_op/z in, datapath strobes out
//   step   (SINGLE_STEP_EN only) advance out of HOLD into the next FETCH
// Parameters:
//   RESET_WAIT  INIT cycles after reset deasserts before leaving INIT (1..15)
// Optional build macro:
//   SINGLE_STEP_EN  adds HOLD after INIT and after every completed instruction
module stack_controller #(
    parameter int RESET_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    stack_controller_if.master bus
`ifdef SINGLE_STEP_EN
    ,
    input  logic               step
`endif
);

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        ALU_POP2 = 4'd3,
        ALU_EXEC = 4'd4,
        ALU_PUSH = 4'd5,
        PUSH_MEM = 4'd6,
        POP_MEM  = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        HOLD     = 4'd8
`endif
    } state_t;

    typedef struct packed {
        logic ir_write;
        logic B_write;
        logic pc_src;
        logic pc_write;
        logic mem_src;
        logic mem_write;
        logic stack_src;
        logic tos;
        logic push;
        logic pop;
        logic instr_done;
    } ctrl_t;

    state_t     state;
    state_t     next_state;
    state_t     done_next;
    logic [3:0] init_cnt;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl;

    // Strobes that depend only on the state; DECODE contributes nothing here
    // because its strobes follow the opcode latched on the same edge.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_src  = 1'b1;
                c.ir_write = 1'b1;
                c.pc_src   = 1'b1;
                c.pc_write = 1'b1;
            end
            ALU_POP2: begin
                c.tos = 1'b1;
                c.pop = 1'b1;
            end
            ALU_PUSH: begin
                c.stack_src  = 1'b1;
                c.push       = 1'b1;
                c.instr_done = 1'b1;
            end
            PUSH_MEM: begin
                c.push       = 1'b1;
                c.instr_done = 1'b1;
            end
            POP_MEM: begin
                c.tos        = 1'b1;
                c.mem_write  = 1'b1;
                c.pop        = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [2:0] op, input logic zf);
        ctrl_t c;
        c = '0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
                // First operand moves into B and leaves the stack.
                c.tos     = 1'b1;
                c.B_write = 1'b1;
                c.pop     = 1'b1;
            end
            3'b110: begin
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            3'b111: begin
                // Peek only: the tested value stays on the stack.
                c.tos        = 1'b1;
                c.pc_write   = zf;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

`ifdef SINGLE_STEP_EN
    assign done_next = HOLD;
`else
    assign done_next = FETCH;
`endif

    always_comb begin
        next_state = state;
        case (state)
            INIT:
                if (init_cnt == 4'(RESET_WAIT - 1)) next_state = done_next;
            FETCH:
                next_state = DECODE;
            DECODE:
                case (bus.inst_op)
                    3'b000, 3'b001, 3'b010: next_state = ALU_POP2;
                    3'b011:                 next_state = ALU_EXEC;
                    3'b100:                 next_state = PUSH_MEM;
                    3'b101:                 next_state = POP_MEM;
                    3'b110, 3'b111:         next_state = done_next;
                    default:                next_state = FETCH;
                endcase
            ALU_POP2:
                next_state = ALU_EXEC;
            ALU_EXEC:
                next_state = ALU_PUSH;
            ALU_PUSH, PUSH_MEM, POP_MEM:
                next_state = done_next;
`ifdef SINGLE_STEP_EN
            HOLD:
                if (step) next_state = FETCH;
`endif
            default:
                next_state = INIT;
        endcase
    end

    // Moore strobes are registered against the state being entered so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= 4'd0;
            ctrl_q   <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= moore_ctrl(next_state);
            if (state == INIT && next_state == INIT) begin
                init_cnt <= init_cnt + 4'd1;
            end else begin
                init_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        ctrl = ctrl_q;
        if (state == DECODE) ctrl = decode_ctrl(bus.inst_op, bus.z);
    end

    assign bus.ir_write   = ctrl.ir_write;
    assign bus.B_write    = ctrl.B_write;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.mem_src    = ctrl.mem_src;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.stack_src  = ctrl.stack_src;
    assign bus.tos        = ctrl.tos;
    assign bus.push       = ctrl.push;
    assign bus.pop        = ctrl.pop;
    assign bus.instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - scoreboard bench for stack_controller strobe sequences
module tb_stack_controller;

    logic       clk;
    logic       reset;
    logic [2:0] inst_op;
    logic       z;
`ifdef SINGLE_STEP_EN
    logic       step;
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    int compared;
    int mismatched;

    // {ir_write,B_write,pc_src,pc_write,mem_src,mem_write,stack_src,tos,push,pop,instr_done}
    localparam logic [10:0] E_NONE     = 11'b000_0000_0000;
    localparam logic [10:0] E_FETCH    = 11'b101_1100_0000;
    localparam logic [10:0] E_DEC_ALU  = 11'b010_0000_1010;
    localparam logic [10:0] E_POP2     = 11'b000_0000_1010;
    localparam logic [10:0] E_ALU_PUSH = 11'b000_0001_0101;
    localparam logic [10:0] E_PUSH_MEM = 11'b000_0000_0101;
    localparam logic [10:0] E_POP_MEM  = 11'b000_0010_1011;
    localparam logic [10:0] E_JMP      = 11'b000_1000_0001;
    localparam logic [10:0] E_JZ1      = 11'b000_1000_1001;
    localparam logic [10:0] E_JZ0      = 11'b000_0000_1001;

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic        zf;
        logic        stp;
        logic [10:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t e;

    stack_controller_if bus_if();

    assign bus_if.inst_op = inst_op;
    assign bus_if.z       = z;

    stack_controller #(.RESET_WAIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef SINGLE_STEP_EN
        ,
        .step  (step)
`endif
    );

    wire [10:0] obs = {bus_if.ir_write, bus_if.B_write, bus_if.pc_src, bus_if.pc_write,
                       bus_if.mem_src, bus_if.mem_write, bus_if.stack_src, bus_if.tos,
                       bus_if.push, bus_if.pop, bus_if.instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [2:0] op, input logic zf,
                       input logic stp, input logic [10:0] exp, input string name);
        sb_entry_t n;
        n.rst = rst; n.op = op; n.zf = zf; n.stp = stp; n.exp = exp; n.name = name;
        sb.push_back(n);
    endtask

    task automatic drive(input sb_entry_t d);
        @(negedge clk);
        reset   = d.rst;
        inst_op = d.op;
        z       = d.zf;
`ifdef SINGLE_STEP_EN
        step    = d.stp;
`endif
        #1;
    endtask

    // Pushes the expected per-cycle strobes of one instruction.
    task automatic add_instr(input logic [2:0] op, input logic zf, input string name);
        if (SS) add(1'b0, op, zf, 1'b1, E_NONE, {name, "_hold"});
        add(1'b0, op, zf, 1'b1, E_FETCH, {name, "_fetch"});
        case (op)
            3'b000, 3'b001, 3'b010: begin
                add(1'b0, op, zf, 1'b1, E_DEC_ALU,  {name, "_decode"});
                add(1'b0, op, zf, 1'b1, E_POP2,     {name, "_pop2"});
                add(1'b0, op, zf, 1'b1, E_NONE,     {name, "_exec"});
                add(1'b0, op, zf, 1'b1, E_ALU_PUSH, {name, "_push"});
            end
            3'b011: begin
                add(1'b0, op, zf, 1'b1, E_DEC_ALU,  {name, "_decode"});
                add(1'b0, op, zf, 1'b1, E_NONE,     {name, "_exec"});
                add(1'b0, op, zf, 1'b1, E_ALU_PUSH, {name, "_push"});
            end
            3'b100: begin
                add(1'b0, op, zf, 1'b1, E_NONE,     {name, "_decode"});
                add(1'b0, op, zf, 1'b1, E_PUSH_MEM, {name, "_pushmem"});
            end
            3'b101: begin
                add(1'b0, op, zf, 1'b1, E_NONE,     {name, "_decode"});
                add(1'b0, op, zf, 1'b1, E_POP_MEM,  {name, "_popmem"});
            end
            3'b110:  add(1'b0, op, zf, 1'b1, E_JMP, {name, "_decode"});
            default: add(1'b0, op, zf, 1'b1, zf ? E_JZ1 : E_JZ0, {name, "_decode"});
        endcase
    endtask

    task automatic test_reset;
        add(1'b1, 3'b000, 1'b0, 1'b1, E_NONE, "reset_held");
        add(1'b0, 3'b000, 1'b0, 1'b1, E_NONE, "reset_init");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_push_pop;
        add_instr(3'b100, 1'b0, "push");
        add_instr(3'b101, 1'b0, "pop");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_alu;
        add_instr(3'b000, 1'b0, "add");
        add_instr(3'b001, 1'b1, "sub");
        add_instr(3'b010, 1'b0, "and");
        add_instr(3'b011, 1'b0, "not");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_jumps;
        add_instr(3'b110, 1'b0, "jmp");
        add_instr(3'b111, 1'b1, "jz_taken");
        add_instr(3'b111, 1'b0, "jz_not_taken");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        if (SS) add(1'b0, 3'b000, 1'b0, 1'b1, E_NONE, "rmid_hold");
        add(1'b0, 3'b000, 1'b0, 1'b1, E_FETCH,   "rmid_fetch");
        add(1'b0, 3'b000, 1'b0, 1'b1, E_DEC_ALU, "rmid_decode");
        add(1'b1, 3'b000, 1'b0, 1'b1, E_POP2,    "rmid_pop2");
        add(1'b0, 3'b000, 1'b0, 1'b1, E_NONE,    "rmid_after_reset");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 24; i++) begin
            add_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $sformatf("b2b%0d", i));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
            compared++;
            if ((bus_if.push & bus_if.pop) !== 1'b0) begin
                mismatched++;
                $display("FAIL %s_push_pop_excl: got push=%b pop=%b expected not both", e.name,
                         bus_if.push, bus_if.pop);
            end
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step;
        for (int i = 0; i < 10; i++) add(1'b0, 3'b110, 1'b0, 1'b0, E_NONE, $sformatf("hold%0d", i));
        add(1'b0, 3'b110, 1'b0, 1'b1, E_NONE,  "hold_step");
        add(1'b0, 3'b110, 1'b0, 1'b0, E_FETCH, "step_fetch");
        add(1'b0, 3'b110, 1'b0, 1'b0, E_JMP,   "step_jmp");
        for (int i = 0; i < 3; i++) add(1'b0, 3'b110, 1'b0, 1'b0, E_NONE, $sformatf("rehold%0d", i));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            compared++;
            if (obs !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        inst_op    = 3'b000;
        z          = 1'b0;
`ifdef SINGLE_STEP_EN
        step       = 1'b1;
`endif
        @(posedge clk);
        test_reset;
        test_push_pop;
        test_alu;
        test_jumps;
`ifdef SINGLE_STEP_EN
        test_single_step;
`endif
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
